// File: rtl/des_key_sched.sv
// DES key schedule front end: PC-1 permutation and per-round C/D rotation.
// Emits one C||D value per round over a valid/ready handshake, in either order.
module des_key_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key,
    output logic [55:0] cd_out,
    output logic [3:0]  round,
    output logic        cd_valid,
    input  logic        cd_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // PC-1 source bit for each output bit, output bit 1 first
    localparam logic [335:0] PC1_TBL = {
        6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
        6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
        6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
        6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
        6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
        6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
        6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
        6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
    };

    state_t      state;
    state_t      state_nxt;
    logic        dec_q;
    logic        xfer;
    logic        last;
    logic [55:0] key_pc1;
    logic [55:0] cd_load;
    logic [55:0] cd_step;
    logic [4:0]  sh_r;
    logic        two;

    // Key bit n (1 = MSB) lives at key[64-n]
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        logic [5:0]  p;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            p = PC1_TBL[(55 - i) * 6 +: 6];
            r[55 - i] = k[6'd63 - (p - 6'd1)];
        end
        return r;
    endfunction

    // Rounds 1, 2, 9 and 16 shift by one, all others by two
    function automatic logic shift_two(input logic [4:0] r);
        return !((r == 5'd1) || (r == 5'd2) ||
                 (r == 5'd9) || (r == 5'd16));
    endfunction

    function automatic logic [27:0] rotl28(
        input logic [27:0] x,
        input logic        by2
    );
        return by2 ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr28(
        input logic [27:0] x,
        input logic        by2
    );
        return by2 ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    assign xfer = cd_valid & cd_ready;
    assign last = (round == 4'd15);
    assign busy = (state != IDLE);
    assign done = (state == FIN);

    // First entry: encrypt starts at C1D1, decrypt at C16D16 = C0D0
    always_comb begin
        key_pc1 = pc1(key);
        cd_load = key_pc1;
        if (!decrypt) begin
            cd_load = {rotl28(key_pc1[55:28], 1'b0),
                       rotl28(key_pc1[27:0], 1'b0)};
        end
    end

    // Next entry: step forward (encrypt) or backward (decrypt) one round
    always_comb begin
        sh_r = dec_q ? (5'd16 - {1'b0, round})
                     : ({1'b0, round} + 5'd2);
        two = shift_two(sh_r);
        cd_step = {rotl28(cd_out[55:28], two),
                   rotl28(cd_out[27:0], two)};
        if (dec_q) begin
            cd_step = {rotr28(cd_out[55:28], two),
                       rotr28(cd_out[27:0], two)};
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if (xfer && last) state_nxt = FIN;
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // C||D register, round index and valid flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cd_out   <= '0;
            round    <= '0;
            cd_valid <= 1'b0;
            dec_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cd_out   <= cd_load;
                        round    <= 4'd0;
                        cd_valid <= 1'b1;
                        dec_q    <= decrypt;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        if (last) begin
                            cd_valid <= 1'b0;
                        end else begin
                            cd_out <= cd_step;
                            round  <= round + 4'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_des_key_sched.sv
// Self-checking bench for des_key_sched against a cumulative-shift
// model of the DES key schedule built directly from PC-1 and the shift table.
module tb_des_key_sched;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        decrypt;
    logic [63:0] key;
    logic [55:0] cd_out;
    logic [3:0]  round;
    logic        cd_valid;
    logic        cd_ready;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [63:0] KEY_REF = 64'h133457799BBCDFF1;
    localparam logic [55:0] CD1     = 56'hE19955FAACCF1E;
    localparam logic [55:0] CD0     = 56'hF0CCAAF556678F;
    localparam logic [55:0] CD15    = 56'hF866557AAB33C7;

    int pc1_pos [56] = '{
        57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
        10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
        14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4
    };

    // exp_cd[r] = CrDr, r = 0..16
    logic [55:0] exp_cd [0:16];

    des_key_sched dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .decrypt  (decrypt),
        .key      (key),
        .cd_out   (cd_out),
        .round    (round),
        .cd_valid (cd_valid),
        .cd_ready (cd_ready),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(
        input string       tag,
        input logic [63:0] obs,
        input logic [63:0] exp
    );
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [27:0] rotl_n(input logic [27:0] x, input int n);
        logic [55:0] d;
        d = {x, x} << n;
        return d[55:28];
    endfunction

    task automatic build_model(input logic [63:0] k);
        logic [27:0] c0;
        logic [27:0] d0;
        int s;
        for (int i = 0; i < 28; i++) begin
            c0[27 - i] = k[64 - pc1_pos[i]];
            d0[27 - i] = k[64 - pc1_pos[28 + i]];
        end
        s = 0;
        exp_cd[0] = {c0, d0};
        for (int r = 1; r <= 16; r++) begin
            s += (r == 1 || r == 2 || r == 9 || r == 16) ? 1 : 2;
            exp_cd[r] = {rotl_n(c0, s % 28), rotl_n(d0, s % 28)};
        end
    endtask

    task automatic run(
        input  logic [63:0] k,
        input  logic [63:0] model_k,
        input  bit          dec,
        input  int          stall_pct,
        input  bit          poke,
        output logic [55:0] first,
        output logic [55:0] lastv
    );
        int n;
        int cyc;
        bit rdy;
        build_model(model_k);
        first = '0;
        lastv = '0;
        @(negedge clk);
        start = 1'b1;
        key = k;
        decrypt = dec;
        cd_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        decrypt = ~dec;
        key = {$urandom, $urandom};
        n = 0;
        cyc = 0;
        while (n < 16 && cyc < 400) begin
            chk("valid", 64'(cd_valid), 64'd1);
            chk("busy", 64'(busy), 64'd1);
            chk("round", 64'(round), 64'(n));
            chk("cd", 64'(cd_out),
                64'(dec ? exp_cd[16 - n] : exp_cd[n + 1]));
            if (n == 0) first = cd_out;
            if (n == 15) lastv = cd_out;
            rdy = ($urandom_range(99) >= stall_pct);
            cd_ready = rdy;
            if (poke) begin
                start = 1'($urandom_range(1));
                key = {$urandom, $urandom};
                decrypt = 1'($urandom_range(1));
            end
            @(negedge clk);
            if (rdy) n++;
            cyc++;
        end
        if (n < 16) chk("xfer_timeout", 64'(n), 64'd16);
        start = 1'b0;
        cd_ready = 1'b1;
        chk("done_pulse", 64'(done), 64'd1);
        chk("fin_valid", 64'(cd_valid), 64'd0);
        @(negedge clk);
        chk("done_clr", 64'(done), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [55:0] f;
        logic [55:0] l;
        logic [63:0] rk;
        int cyc;
        rst_n = 1'b0;
        start = 1'b0;
        decrypt = 1'b0;
        key = '0;
        cd_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cd", 64'(cd_out), 64'd0);
        chk("rst_round", 64'(round), 64'd0);
        chk("rst_valid", 64'(cd_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reference encrypt and decrypt
        run(KEY_REF, KEY_REF, 1'b0, 0, 1'b0, f, l);
        chk("enc_r0", 64'(f), 64'(CD1));
        chk("enc_r15", 64'(l), 64'(CD0));
        run(KEY_REF, KEY_REF, 1'b1, 0, 1'b0, f, l);
        chk("dec_r0", 64'(f), 64'(CD0));
        chk("dec_r15", 64'(l), 64'(CD1));
        build_model(KEY_REF);
        chk("model_dec_r1", 64'(exp_cd[15]), 64'(CD15));

        // Backpressure, ignored start/key during RUN, parity flip
        run(KEY_REF, KEY_REF, 1'b0, 30, 1'b0, f, l);
        chk("stall_r0", 64'(f), 64'(CD1));
        run(KEY_REF, KEY_REF, 1'b0, 0, 1'b1, f, l);
        chk("poke_r15", 64'(l), 64'(CD0));
        run(KEY_REF ^ 64'h0101010101010101, KEY_REF, 1'b0, 20, 1'b0, f, l);
        chk("parity_r0", 64'(f), 64'(CD1));

        // Random keys in both orders
        for (int t = 0; t < 6; t++) begin
            rk = {$urandom, $urandom};
            run(rk, rk, 1'(t % 2), 25, 1'(t > 3), f, l);
        end

        // Abort with reset at round 7 while stalled
        build_model(KEY_REF);
        @(negedge clk);
        start = 1'b1;
        key = KEY_REF;
        decrypt = 1'b0;
        cd_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (round != 4'd7 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort_reach7", 64'(round), 64'd7);
        cd_ready = 1'b0;
        @(negedge clk);
        chk("abort_hold_rd", 64'(round), 64'd7);
        chk("abort_hold_cd", 64'(cd_out), 64'(exp_cd[8]));
        #2 rst_n = 1'b0;
        #1;
        chk("abort_cd", 64'(cd_out), 64'd0);
        chk("abort_round", 64'(round), 64'd0);
        chk("abort_valid", 64'(cd_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_done", 64'(done), 64'd0);
            chk("post_rst_busy", 64'(busy), 64'd0);
        end
        run(KEY_REF, KEY_REF, 1'b0, 0, 1'b0, f, l);
        chk("post_rst_r0", 64'(f), 64'(CD1));

        // start held high: restart right after returning to IDLE
        build_model(KEY_REF);
        @(negedge clk);
        start = 1'b1;
        key = KEY_REF;
        decrypt = 1'b0;
        cd_ready = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 40);
        chk("hold_done", 64'(done), 64'd1);
        chk("hold_len", 64'(cyc), 64'd17);
        @(negedge clk);
        chk("hold_idle", 64'(busy), 64'd0);
        @(negedge clk);
        chk("hold_valid", 64'(cd_valid), 64'd1);
        chk("hold_round", 64'(round), 64'd0);
        chk("hold_cd", 64'(cd_out), 64'(exp_cd[1]));
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("hold_done2", 64'(done), 64'd1);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
